// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Reads the synchronous instruction memory at the PC supplied by the PC
// register, buffers returned words with their PCs in a small FIFO, and hands
// them to decode over a valid/ready handshake.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-low reset
//   pc_i             current PC from the PC register
//   pc_advance_o     PC consumed this cycle (PC register steps on this edge)
//   flush_i          redirect: drop all buffered and in-flight fetches
//   imem_req_o       instruction memory read strobe
//   imem_addr_o      read address (= pc_i)
//   imem_rdata_i     read data, valid one cycle after imem_req_o
//   instr_valid_o    FIFO head valid
//   instr_ready_i    decode accepts head
//   instr_o          head instruction
//   instr_pc_o       PC of head instruction
//   instr_misalign_o head was fetched from a PC with pc[1:0] != 0
module fetch_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_advance_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_misalign_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [DEPTH-1:0] mem_mis;

    logic [AW-1:0]   rptr, wptr;
    logic [AW:0]     count;
    logic            inflight;
    logic            drop;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_mis;

    logic [AW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    // The in-flight slot is reserved up front so a response always has room;
    // a pop in the same cycle is deliberately not credited.
    assign occupancy = count + {{AW{1'b0}}, inflight};
    assign issue     = reset_i && !flush_i && (occupancy < FULL);
    assign push      = inflight && !drop && !flush_i;
    assign pop       = instr_valid_o && instr_ready_i;

    assign imem_req_o    = issue;
    assign pc_advance_o  = issue;
    assign imem_addr_o   = reset_i ? pc_i : '0;
    assign instr_valid_o = (count != '0);

    // Head outputs are forced to zero when empty so reset shows all-zero outputs
    // even though the storage array itself is not reset.
    assign instr_o          = instr_valid_o ? mem_instr[rptr] : '0;
    assign instr_pc_o       = instr_valid_o ? mem_pc[rptr]    : '0;
    assign instr_misalign_o = instr_valid_o && mem_mis[rptr];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count        <= '0;
            rptr         <= '0;
            wptr         <= '0;
            inflight     <= 1'b0;
            drop         <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
        end else begin
            inflight <= issue;
            drop     <= flush_i && inflight;
            if (issue) begin
                inflight_pc  <= pc_i;
                inflight_mis <= (pc_i[1:0] != 2'b00);
            end
            if (flush_i) begin
                count <= '0;
                rptr  <= '0;
                wptr  <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && reset_i) begin
            mem_instr[wptr] <= imem_rdata_i;
            mem_pc[wptr]    <= inflight_pc;
            mem_mis[wptr]   <= inflight_mis;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk_i;
    logic            reset_i;
    logic [XLEN-1:0] pc_i;
    logic            pc_advance_o;
    logic            flush_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_misalign_o;

    fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .pc_advance_o     (pc_advance_o),
        .flush_i          (flush_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_misalign_o (instr_misalign_o)
    );

    initial clk_i = 1'b0;
    always #50 clk_i = ~clk_i;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0000_0013;
            32'h4:   rom = 32'h0010_0093;
            32'h8:   rom = 32'h0020_0113;
            default: rom = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (imem_req_o) imem_rdata_i <= rom(imem_addr_o);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] log_pc[$];
    logic        log_mis[$];
    logic [31:0] log_data[$];
    int          now;
    int          n_pass;
    int          n_total;

    // One clock cycle: sample mid-cycle, score, then step the PC register model.
    task automatic cycle();
        logic   adv;
        logic   exp_valid;
        logic   exp_issue;
        entry_t e;
        @(negedge clk_i);
        exp_valid = (sb.size() > 0) && (sb[0].cyc <= now - 2);
        exp_issue = !flush_i && (sb.size() < DEPTH);
        n_total++;
        if (instr_valid_o !== exp_valid)
            $display("FAIL valid cyc=%0d got=%b exp=%b", now, instr_valid_o, exp_valid);
        else n_pass++;
        n_total++;
        if ({imem_req_o, pc_advance_o} !== {exp_issue, exp_issue})
            $display("FAIL issue cyc=%0d req=%b adv=%b exp=%b", now, imem_req_o, pc_advance_o, exp_issue);
        else n_pass++;
        if (instr_valid_o && instr_ready_i && exp_valid) begin
            e = sb.pop_front();
            n_total++;
            if ({instr_pc_o, instr_o, instr_misalign_o} !== {e.pc, e.data, e.mis})
                $display("FAIL head cyc=%0d got pc=%h d=%h m=%b exp pc=%h d=%h m=%b",
                         now, instr_pc_o, instr_o, instr_misalign_o, e.pc, e.data, e.mis);
            else n_pass++;
            log_pc.push_back(instr_pc_o);
            log_data.push_back(instr_o);
            log_mis.push_back(instr_misalign_o);
        end
        if (imem_req_o) begin
            n_total++;
            if (imem_addr_o !== pc_i)
                $display("FAIL addr cyc=%0d got=%h exp=%h", now, imem_addr_o, pc_i);
            else n_pass++;
            sb.push_back('{pc: pc_i, data: rom(pc_i), mis: (pc_i[1:0] != 2'b00), cyc: now});
        end
        if (flush_i) sb.delete();
        adv = pc_advance_o;
        @(posedge clk_i);
        #1;
        now++;
        if (adv) pc_i = pc_i + 32'd4;
    endtask

    task automatic redirect(input logic [31:0] target);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        pc_i = target;
    endtask

    task automatic clear_log();
        log_pc.delete();
        log_data.delete();
        log_mis.delete();
    endtask

    task automatic check_zero(input string name);
        n_total++;
        if ({imem_req_o, pc_advance_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_misalign_o} !== '0)
            $display("FAIL %s req=%b adv=%b addr=%h v=%b i=%h pc=%h m=%b exp all zero", name,
                     imem_req_o, pc_advance_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_misalign_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        pc_i = 32'h0000_0000;
        flush_i = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        pc_i = 32'h0000_0010;
        #1;
        check_zero("reset_outputs");
        pc_i = 32'h0;
        reset_i = 1'b1;
        now = 0;
    endtask

    task automatic test_basic_stream();
        clear_log();
        instr_ready_i = 1'b1;
        repeat (8) cycle();
        n_total++;
        if (log_pc.size() < 3 || log_pc[0] !== 32'h0 || log_pc[1] !== 32'h4 || log_pc[2] !== 32'h8)
            $display("FAIL basic_pcs got n=%0d exp 0,4,8 first", log_pc.size());
        else n_pass++;
        n_total++;
        if (log_data.size() < 3 || log_data[0] !== 32'h13 || log_data[1] !== 32'h0010_0093
            || log_data[2] !== 32'h0020_0113)
            $display("FAIL basic_data got n=%0d exp 13,00100093,00200113", log_data.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        instr_ready_i = 1'b0;
        redirect(32'h20);
        clear_log();
        repeat (6) cycle();
        n_total++;
        if ({instr_valid_o, instr_pc_o, pc_advance_o, pc_i} !== {1'b1, 32'h20, 1'b0, 32'h28})
            $display("FAIL bp_full got v=%b pc=%h adv=%b pc_i=%h exp v=1 pc=20 adv=0 pc_i=28",
                     instr_valid_o, instr_pc_o, pc_advance_o, pc_i);
        else n_pass++;
        instr_ready_i = 1'b1;
        repeat (8) cycle();
        n_total++;
        if (log_pc.size() < 3 || log_pc[0] !== 32'h20 || log_pc[1] !== 32'h24 || log_pc[2] !== 32'h28)
            $display("FAIL bp_order got n=%0d exp 20,24,28 first", log_pc.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        logic stale;
        instr_ready_i = 1'b0;
        redirect(32'h3C);
        repeat (2) cycle();
        clear_log();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        pc_i = 32'h100;
        instr_ready_i = 1'b1;
        repeat (6) cycle();
        stale = 1'b0;
        foreach (log_pc[i]) if (log_pc[i] == 32'h3C || log_pc[i] == 32'h40) stale = 1'b1;
        n_total++;
        if (log_pc.size() == 0 || log_pc[0] !== 32'h100 || stale)
            $display("FAIL flush_redirect got n=%0d stale=%b exp first pc 100", log_pc.size(), stale);
        else n_pass++;
        flush_i = 1'b1;
        repeat (3) cycle();
        flush_i = 1'b0;
        n_total++;
        if (instr_valid_o !== 1'b0)
            $display("FAIL flush_hold got v=%b exp 0", instr_valid_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ok;
        instr_ready_i = 1'b1;
        redirect(32'h500);
        clear_log();
        repeat (10) cycle();
        ok = (log_pc.size() == 6);
        for (int i = 1; i < log_pc.size(); i++)
            if (log_pc[i] !== log_pc[i-1] + 32'd4) ok = 1'b0;
        n_total++;
        if (!ok || log_pc.size() == 0 || log_pc[0] !== 32'h500)
            $display("FAIL b2b got n=%0d exp 6 consecutive from 500", log_pc.size());
        else n_pass++;
    endtask

    task automatic test_misalign();
        instr_ready_i = 1'b1;
        redirect(32'h102);
        clear_log();
        repeat (5) cycle();
        n_total++;
        if (log_pc.size() == 0 || log_pc[0] !== 32'h102 || log_mis[0] !== 1'b1)
            $display("FAIL misalign got n=%0d exp pc 102 mis 1", log_pc.size());
        else n_pass++;
        redirect(32'h200);
        clear_log();
        repeat (5) cycle();
        n_total++;
        if (log_pc.size() == 0 || log_pc[0] !== 32'h200 || log_mis[0] !== 1'b0)
            $display("FAIL aligned got n=%0d exp pc 200 mis 0", log_pc.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        instr_ready_i = 1'b0;
        redirect(32'h300);
        repeat (2) cycle();
        n_total++;
        if (instr_valid_o !== 1'b1)
            $display("FAIL rm_setup got v=%b exp 1", instr_valid_o);
        else n_pass++;
        #20;
        reset_i = 1'b0;
        #1;
        check_zero("reset_mid_outputs");
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        pc_i = 32'h400;
        reset_i = 1'b1;
        clear_log();
        instr_ready_i = 1'b1;
        repeat (6) cycle();
        n_total++;
        if (log_pc.size() == 0 || log_pc[0] !== 32'h400 || log_data[0] !== rom(32'h400))
            $display("FAIL reset_mid got n=%0d exp first pc 400", log_pc.size());
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        now = 0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
